// File: rtl/jtkicker_rom_serve.sv
// Game ROM responder: three read-only slots with one-entry caches, refilled by 2-word SDRAM bursts.
// Hit -> ok/dout registered one cycle later; misses arbitrated slot2 > slot0 > slot1, one burst in flight.
module jtkicker_rom_serve #(
  parameter int          SLOT0_AW     = 14,
  parameter logic [21:0] SLOT0_OFFSET = 22'd0,
  parameter int          SLOT1_AW     = 14,
  parameter logic [21:0] SLOT1_OFFSET = 22'd0,
  parameter int          SLOT2_AW     = 16,
  parameter logic [21:0] SLOT2_OFFSET = 22'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic                slot1_cs,
  input  logic                slot2_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  output logic                slot0_ok,
  output logic                slot1_ok,
  output logic                slot2_ok,
  output logic [31:0]         slot0_dout,
  output logic [31:0]         slot1_dout,
  output logic [7:0]          slot2_dout,
  output logic                sdram_req,
  output logic [21:0]         sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);
  localparam int T0W = SLOT0_AW - 1;
  localparam int T1W = SLOT1_AW - 1;
  localparam int T2W = SLOT2_AW - 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t st;

  logic [T0W-1:0] ctag0, tag0, ltag0;
  logic [T1W-1:0] ctag1, tag1, ltag1;
  logic [T2W-1:0] ctag2, tag2, ltag2;
  logic [31:0]    data0, data1, data2;
  logic           vld0, vld1, vld2;
  logic           hit0, hit1, hit2, miss0, miss1, miss2;
  logic [21:0]    addr0, addr1, addr2;
  logic [1:0]     sel, cnt;
  logic [15:0]    word0, word1, fill_w0, fill_w1;
  logic           discard;
  logic [7:0]     byte2;

  assign ctag0 = slot0_addr[SLOT0_AW-1:1];
  assign ctag1 = slot1_addr[SLOT1_AW-1:1];
  assign ctag2 = slot2_addr[SLOT2_AW-1:2];

  assign hit0  = slot0_cs & vld0 & (tag0 == ctag0);
  assign hit1  = slot1_cs & vld1 & (tag1 == ctag1);
  assign hit2  = slot2_cs & vld2 & (tag2 == ctag2);
  assign miss0 = slot0_cs & ~hit0;
  assign miss1 = slot1_cs & ~hit1;
  assign miss2 = slot2_cs & ~hit2;

  // 22-bit sums wrap: carry out of the offset addition is dropped
  assign addr0 = SLOT0_OFFSET + 22'({ctag0, 1'b0});
  assign addr1 = SLOT1_OFFSET + 22'({ctag1, 1'b0});
  assign addr2 = SLOT2_OFFSET + 22'({ctag2, 1'b0});

  // A strobe landing together with data_rdy still makes it into the fill
  assign fill_w0 = (data_dst && cnt == 2'd0) ? data_read : word0;
  assign fill_w1 = (data_dst && cnt == 2'd1) ? data_read : word1;

  always_comb begin
    byte2 = data2[7:0];
    case (slot2_addr[1:0])
      2'd0: byte2 = data2[7:0];
      2'd1: byte2 = data2[15:8];
      2'd2: byte2 = data2[23:16];
      2'd3: byte2 = data2[31:24];
      default: byte2 = data2[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      sel        <= 2'd0;
      cnt        <= 2'd0;
      discard    <= 1'b0;
      vld0       <= 1'b0;
      vld1       <= 1'b0;
      vld2       <= 1'b0;
      slot0_ok   <= 1'b0;
      slot1_ok   <= 1'b0;
      slot2_ok   <= 1'b0;
      slot0_dout <= 32'd0;
      slot1_dout <= 32'd0;
      slot2_dout <= 8'd0;
    end else begin
      slot0_ok <= hit0 & ~downloading;
      slot1_ok <= hit1 & ~downloading;
      slot2_ok <= hit2 & ~downloading;
      if (hit0) slot0_dout <= data0;
      if (hit1) slot1_dout <= data1;
      if (hit2) slot2_dout <= byte2;

      case (st)
        IDLE: begin
          if (!downloading && (miss0 || miss1 || miss2)) begin
            sdram_req <= 1'b1;
            discard   <= 1'b0;
            ltag0     <= ctag0;
            ltag1     <= ctag1;
            ltag2     <= ctag2;
            st        <= REQ;
            if (miss2) begin
              sel        <= 2'd2;
              sdram_addr <= addr2;
            end else if (miss0) begin
              sel        <= 2'd0;
              sdram_addr <= addr0;
            end else begin
              sel        <= 2'd1;
              sdram_addr <= addr1;
            end
          end
        end
        REQ: begin
          if (downloading) discard <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            cnt       <= 2'd0;
            st        <= WAIT;
          end
        end
        WAIT: begin
          if (downloading) discard <= 1'b1;
          if (data_dst && cnt != 2'd2) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0) word0 <= data_read;
            else             word1 <= data_read;
          end
          if (data_rdy) begin
            st <= IDLE;
            // Data fetched across a ROM download is stale: never cache it
            if (!discard && !downloading) begin
              case (sel)
                2'd0: begin vld0 <= 1'b1; tag0 <= ltag0; data0 <= {fill_w1, fill_w0}; end
                2'd1: begin vld1 <= 1'b1; tag1 <= ltag1; data1 <= {fill_w1, fill_w0}; end
                default: begin vld2 <= 1'b1; tag2 <= ltag2; data2 <= {fill_w1, fill_w0}; end
              endcase
            end
          end
        end
        default: st <= IDLE;
      endcase

      if (downloading) begin
        vld0 <= 1'b0;
        vld1 <= 1'b0;
        vld2 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jtkicker_rom_serve.sv
// Directed scenarios plus a randomized phase with an SDRAM responder and arithmetic reference model.
module tb_jtkicker_rom_serve;
  localparam logic [21:0] OFF0 = 22'h010000;
  localparam logic [21:0] OFF1 = 22'h3FFFF0;
  localparam logic [21:0] OFF2 = 22'h000000;

  logic        clk = 1'b0;
  logic        rst, downloading;
  logic        slot0_cs, slot1_cs, slot2_cs;
  logic [13:0] slot0_addr, slot1_addr;
  logic [15:0] slot2_addr;
  logic        slot0_ok, slot1_ok, slot2_ok;
  logic [31:0] slot0_dout, slot1_dout;
  logic [7:0]  slot2_dout;
  logic        sdram_req, sdram_ack, data_dst, data_rdy;
  logic [21:0] sdram_addr;
  logic [15:0] data_read;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtkicker_rom_serve #(
    .SLOT0_AW(14), .SLOT0_OFFSET(OFF0),
    .SLOT1_AW(14), .SLOT1_OFFSET(OFF1),
    .SLOT2_AW(16), .SLOT2_OFFSET(OFF2)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot1_cs(slot1_cs), .slot2_cs(slot2_cs),
    .slot0_addr(slot0_addr), .slot1_addr(slot1_addr), .slot2_addr(slot2_addr),
    .slot0_ok(slot0_ok), .slot1_ok(slot1_ok), .slot2_ok(slot2_ok),
    .slot0_dout(slot0_dout), .slot1_dout(slot1_dout), .slot2_dout(slot2_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
  );

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], a[21:12]} ^ 16'hA5C3;
  endfunction

  // Reference mapping: word-pair base for each slot's address
  function automatic logic [21:0] base0(input logic [13:0] a);
    return OFF0 + 22'(a & 14'h3FFE);
  endfunction
  function automatic logic [21:0] base1(input logic [13:0] a);
    return OFF1 + 22'(a & 14'h3FFE);
  endfunction
  function automatic logic [21:0] base2(input logic [15:0] a);
    return OFF2 + 22'((a >> 2) * 2);
  endfunction
  function automatic logic [31:0] pair(input logic [21:0] b);
    return {mem_word(b + 22'd1), mem_word(b)};
  endfunction
  function automatic logic [7:0] byte_of(input logic [15:0] a);
    logic [15:0] w;
    w = mem_word(base2(a) + 22'(a[1]));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [21:0] exp);
    int n = 0;
    while (!sdram_req && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(sdram_req), 32'd1);
    chk({tag, "_addr"}, 32'(sdram_addr), 32'(exp));
  endtask

  task automatic do_ack();
    repeat ($urandom_range(0, 2)) tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic do_dst(input logic [15:0] w, input bit with_rdy);
    repeat ($urandom_range(0, 2)) tick();
    data_dst  = 1'b1;
    data_read = w;
    data_rdy  = with_rdy;
    tick();
    data_dst = 1'b0;
    data_rdy = 1'b0;
  endtask

  task automatic do_rdy();
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [21:0] exp);
    bit same;
    same = 1'($urandom_range(0, 1));
    wait_req(tag, exp);
    do_ack();
    do_dst(mem_word(exp), 1'b0);
    do_dst(mem_word(exp + 22'd1), same);
    if (!same) do_rdy();
  endtask

  int          rs, stab0, stab1, stab2, dl_left;
  logic [21:0] ra;
  logic        p_cs0, p_cs1, p_cs2, p_dl, last_req, cand;
  logic [13:0] p_a0, p_a1;
  logic [15:0] p_a2;

  initial begin
    rst = 1'b1; downloading = 1'b0;
    slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0;
    slot0_addr = '0; slot1_addr = '0; slot2_addr = '0;
    sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) tick();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_ok", 32'({slot0_ok, slot1_ok, slot2_ok}), 32'd0);
    chk("rst_dout0", slot0_dout, 32'd0);
    chk("rst_dout1", slot1_dout, 32'd0);
    chk("rst_dout2", 32'(slot2_dout), 32'd0);
    rst = 1'b0;

    // Byte-addressed slot: first fill and byte selection
    slot2_cs = 1'b1; slot2_addr = 16'h0005;
    wait_req("t1", 22'h2);
    do_ack();
    chk("t1_req_drop", 32'(sdram_req), 32'd0);
    do_dst(16'hBBAA, 1'b0);
    do_dst(16'hDDCC, 1'b0);
    do_rdy();
    tick();
    chk("t1_ok", 32'(slot2_ok), 32'd1);
    chk("t1_dout", 32'(slot2_dout), 32'hBB);

    // Same tag, different byte: served from the cache
    slot2_addr = 16'h0006;
    tick();
    chk("t2_ok", 32'(slot2_ok), 32'd1);
    chk("t2_dout", 32'(slot2_dout), 32'hCC);
    tick();
    chk("t2_noreq", 32'(sdram_req), 32'd0);

    // Simultaneous misses resolve slot2, slot0, slot1; slot1 address wraps at 22 bits
    slot2_addr = 16'h0100;
    slot0_cs = 1'b1; slot0_addr = 14'h0011;
    slot1_cs = 1'b1; slot1_addr = 14'h0022;
    serve("t3_s2", 22'h000080);
    serve("t3_s0", 22'h010010);
    serve("t3_s1", 22'h000012);
    tick();
    chk("t3_ok", 32'({slot0_ok, slot1_ok, slot2_ok}), 32'h7);
    chk("t3_dout0", slot0_dout, pair(22'h010010));
    chk("t3_dout1", slot1_dout, pair(22'h000012));
    chk("t3_dout2", 32'(slot2_dout), 32'(mem_word(22'h80) & 16'hFF));

    // Address change mid-burst: old fill lands but never matches
    slot1_cs = 1'b0; slot2_cs = 1'b0;
    slot0_addr = 14'h0040;
    wait_req("t4a", 22'h010040);
    do_ack();
    do_dst(mem_word(22'h010040), 1'b0);
    slot0_addr = 14'h0080;
    do_dst(mem_word(22'h010041), 1'b1);
    chk("t4_ok_stale", 32'(slot0_ok), 32'd0);
    tick();
    chk("t4_ok_stale2", 32'(slot0_ok), 32'd0);
    serve("t4b", 22'h010080);
    tick();
    chk("t4_ok", 32'(slot0_ok), 32'd1);
    chk("t4_dout", slot0_dout, pair(22'h010080));

    // Reset during WAIT: burst abandoned, nothing cached
    slot0_addr = 14'h00C0;
    wait_req("t5a", 22'h0100C0);
    do_ack();
    do_dst(mem_word(22'h0100C0), 1'b0);
    rst = 1'b1;
    tick();
    data_dst = 1'b1; data_rdy = 1'b1; data_read = 16'hDEAD;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0;
    chk("t5_req", 32'(sdram_req), 32'd0);
    chk("t5_ok", 32'({slot0_ok, slot1_ok, slot2_ok}), 32'd0);
    chk("t5_dout0", slot0_dout, 32'd0);
    rst = 1'b0;
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    serve("t5b", 22'h0100C0);
    tick();
    chk("t5_ok_after", 32'(slot0_ok), 32'd1);
    chk("t5_dout_after", slot0_dout, pair(22'h0100C0));

    // Download flushes every entry; afterwards the same addresses are refetched
    slot2_cs = 1'b1;
    serve("t6a", 22'h000080);
    tick();
    chk("t6_ok_pre", 32'({slot0_ok, slot2_ok}), 32'h3);
    downloading = 1'b1;
    tick();
    chk("t6_ok_dl", 32'({slot0_ok, slot1_ok, slot2_ok}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_noreq", 32'(sdram_req), 32'd0);
    end
    downloading = 1'b0;
    serve("t6b", 22'h000080);
    serve("t6c", 22'h0100C0);
    tick();
    chk("t6_ok_post", 32'({slot0_ok, slot2_ok}), 32'h3);

    // Randomized traffic against the arithmetic model
    rs = 0; stab0 = 0; stab1 = 0; stab2 = 0; dl_left = 0;
    p_cs0 = slot0_cs; p_cs1 = slot1_cs; p_cs2 = slot2_cs; p_dl = downloading;
    p_a0 = slot0_addr; p_a1 = slot1_addr; p_a2 = slot2_addr;
    last_req = sdram_req;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (slot0_ok) chk("r_dout0", slot0_dout, pair(base0(p_a0)));
      if (slot1_ok) chk("r_dout1", slot1_dout, pair(base1(p_a1)));
      if (slot2_ok) chk("r_dout2", 32'(slot2_dout), 32'(byte_of(p_a2)));
      if (slot0_ok || slot1_ok || slot2_ok)
        chk("r_ok_cs", 32'({slot0_ok & ~p_cs0, slot1_ok & ~p_cs1, slot2_ok & ~p_cs2}), 32'd0);
      if (p_dl) chk("r_dl_ok", 32'({slot0_ok, slot1_ok, slot2_ok}), 32'd0);
      if (sdram_req && !last_req) begin
        cand = (p_cs0 && sdram_addr == base0(p_a0)) || (p_cs1 && sdram_addr == base1(p_a1)) ||
               (p_cs2 && sdram_addr == base2(p_a2));
        chk("r_req_addr", 32'(cand), 32'd1);
        chk("r_req_dl", 32'(p_dl), 32'd0);
      end
      if (stab0 == 80) chk("r_live0", 32'(slot0_ok), 32'd1);
      if (stab1 == 80) chk("r_live1", 32'(slot1_ok), 32'd1);
      if (stab2 == 80) chk("r_live2", 32'(slot2_ok), 32'd1);
      last_req = sdram_req;

      sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0;
      case (rs)
        0: if (sdram_req && $urandom_range(0, 1) == 0) begin
             sdram_ack = 1'b1; ra = sdram_addr; rs = 1;
           end
        1: if ($urandom_range(0, 1) == 0) begin
             data_dst = 1'b1; data_read = mem_word(ra); rs = 2;
           end
        2: if ($urandom_range(0, 1) == 0) begin
             data_dst = 1'b1; data_read = mem_word(ra + 22'd1);
             if ($urandom_range(0, 1) == 0) begin data_rdy = 1'b1; rs = 0; end
             else rs = 3;
           end
        default: begin
          if ($urandom_range(0, 3) == 0) begin data_dst = 1'b1; data_read = 16'hDEAD; end
          if ($urandom_range(0, 1) == 0) begin data_rdy = 1'b1; rs = 0; end
        end
      endcase

      if ($urandom_range(0, 59) == 0) slot0_cs = ~slot0_cs;
      if ($urandom_range(0, 59) == 0) slot1_cs = ~slot1_cs;
      if ($urandom_range(0, 59) == 0) slot2_cs = ~slot2_cs;
      if ($urandom_range(0, 59) == 0)
        slot0_addr = ($urandom_range(0, 7) == 7) ? 14'h3FFF : 14'(($urandom_range(0, 6) << 4) | $urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0)
        slot1_addr = ($urandom_range(0, 7) == 7) ? 14'h3FFF : 14'(($urandom_range(0, 6) << 4) | $urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0)
        slot2_addr = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      if (dl_left > 0) dl_left--;
      else if ($urandom_range(0, 299) == 0) dl_left = $urandom_range(1, 3);
      downloading = (dl_left > 0);

      stab0 = (slot0_cs && !downloading && p_cs0 && !p_dl && slot0_addr == p_a0) ? stab0 + 1 : 0;
      stab1 = (slot1_cs && !downloading && p_cs1 && !p_dl && slot1_addr == p_a1) ? stab1 + 1 : 0;
      stab2 = (slot2_cs && !downloading && p_cs2 && !p_dl && slot2_addr[15:2] == p_a2[15:2]) ? stab2 + 1 : 0;
      p_cs0 = slot0_cs; p_cs1 = slot1_cs; p_cs2 = slot2_cs; p_dl = downloading;
      p_a0 = slot0_addr; p_a1 = slot1_addr; p_a2 = slot2_addr;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
